rf68000_node_ram_rr_arbiter: RTL and testbench



---
 rtl/rf68000_node_ram_rr_arbiter_if.sv | 45 ++++
 rtl/rf68000_node_ram_rr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_rf68000_node_ram_rr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf68000_node_ram_rr_arbiter_if.sv
// Bus bundle between the CPU port, the NIC port, the node RAM and the RAM arbiter.
// The arbiter side uses modport slave; requesters and RAM model use modport master.
interface rf68000_node_ram_rr_arbiter_if;
    logic        cpu_cyc;
    logic        cpu_stb;
    logic        cpu_we;
    logic [3:0]  cpu_sel;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_dato;
    logic        cpu_ack;
    logic [31:0] cpu_dati;

    logic        nic_cyc;
    logic        nic_stb;
    logic        nic_we;
    logic [3:0]  nic_sel;
    logic [31:0] nic_adr;
    logic [31:0] nic_dato;
    logic        nic_ack;
    logic [31:0] nic_dati;

    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_adr;
    logic [31:0] ram_dati;
    logic [31:0] ram_dato;

    modport slave (
        input  cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_adr, cpu_dato,
        output cpu_ack, cpu_dati,
        input  nic_cyc, nic_stb, nic_we, nic_sel, nic_adr, nic_dato,
        output nic_ack, nic_dati,
        output ram_en, ram_we, ram_adr, ram_dati,
        input  ram_dato
    );

    modport master (
        output cpu_cyc, cpu_stb, cpu_we, cpu_sel, cpu_adr, cpu_dato,
        input  cpu_ack, cpu_dati,
        output nic_cyc, nic_stb, nic_we, nic_sel, nic_adr, nic_dato,
        input  nic_ack, nic_dati,
        input  ram_en, ram_we, ram_adr, ram_dati,
        output ram_dato
    );
endinterface

// File: rtl/rf68000_node_ram_rr_arbiter.sv
// Round-robin CPU/NIC arbiter and sequencer for a node's shared block RAM.
// Optional hung-cycle watchdog enabled by defining RF68000_ARB_WDOG_EN.
module rf68000_node_ram_rr_arbiter #(
    parameter int unsigned RAM_LAT  = 3,
    parameter int unsigned WDOG_CYC = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] id,
    rf68000_node_ram_rr_arbiter_if.slave bus,
    output logic [1:0] gnt,
    output logic       wdog_o
);
    localparam int unsigned CNT_W = 3;
    localparam int unsigned WD_W  = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;

    if (RAM_LAT < 1 || RAM_LAT > 7 || WDOG_CYC < 1 || WDOG_CYC > 255) begin : g_param_check
        $error("rf68000_node_ram_rr_arbiter: RAM_LAT or WDOG_CYC out of range");
    end

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;          // 1 = NIC was granted last
    logic [1:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cpu_ack_q, cpu_ack_d, nic_ack_q, nic_ack_d;
    logic [DW-1:0]    cpu_dati_q, cpu_dati_d, nic_dati_q, nic_dati_d;
    logic             ram_en_q, ram_en_d;
    logic [SW-1:0]    ram_we_q, ram_we_d;
    logic [DW-1:0]    ram_adr_q, ram_adr_d, ram_dati_q, ram_dati_d;

    logic act_cpu, act_nic, cpu_hit, nic_hit, req_cpu, req_nic, act_gnt;

    assign act_cpu = bus.cpu_cyc & bus.cpu_stb;
    assign act_nic = bus.nic_cyc & bus.nic_stb;
    assign cpu_hit = (bus.cpu_adr[31:18] == 14'd0);
    assign nic_hit = (bus.nic_adr[31:20] == {8'hFF, id});
    assign req_cpu = act_cpu & cpu_hit;
    assign req_nic = act_nic;
    assign act_gnt = gnt_q[1] ? act_nic : act_cpu;

`ifdef RF68000_ARB_WDOG_EN
    logic [WD_W-1:0] wcnt_q, wcnt_d;
    logic            wdog_q, wdog_d;
`endif

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        cpu_ack_d  = cpu_ack_q;
        nic_ack_d  = nic_ack_q;
        cpu_dati_d = cpu_dati_q;
        nic_dati_d = nic_dati_q;
        ram_en_d   = ram_en_q;
        ram_we_d   = ram_we_q;
        ram_adr_d  = ram_adr_q;
        ram_dati_d = ram_dati_q;
`ifdef RF68000_ARB_WDOG_EN
        wcnt_d     = '0;
        wdog_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // Contention goes to whoever was not served last
                if (req_nic && (!req_cpu || !last_q)) begin
                    gnt_d  = 2'b10;
                    last_d = 1'b1;
                    if (nic_hit) begin
                        ram_adr_d  = bus.nic_adr;
                        ram_dati_d = bus.nic_dato;
                        ram_we_d   = {SW{bus.nic_we}} & bus.nic_sel;
                        ram_en_d   = 1'b1;
                        cnt_d      = CNT_W'(RAM_LAT - 1);
                        state_d    = bus.nic_we ? WR : RD;
                    end else begin
                        nic_ack_d  = 1'b1;
                        nic_dati_d = '0;
                        state_d    = ACK;
                    end
                end else if (req_cpu) begin
                    gnt_d      = 2'b01;
                    last_d     = 1'b0;
                    ram_adr_d  = bus.cpu_adr;
                    ram_dati_d = bus.cpu_dato;
                    ram_we_d   = {SW{bus.cpu_we}} & bus.cpu_sel;
                    ram_en_d   = 1'b1;
                    cnt_d      = CNT_W'(RAM_LAT - 1);
                    state_d    = bus.cpu_we ? WR : RD;
                end
            end
            WR: begin
                ram_we_d = '0;
                ram_en_d = 1'b0;
                if (gnt_q[1]) nic_ack_d = 1'b1;
                else          cpu_ack_d = 1'b1;
                state_d = ACK;
            end
            RD: begin
                if (cnt_q == '0) begin
                    if (gnt_q[1]) begin
                        nic_dati_d = bus.ram_dato;
                        nic_ack_d  = 1'b1;
                    end else begin
                        cpu_dati_d = bus.ram_dato;
                        cpu_ack_d  = 1'b1;
                    end
                    ram_en_d = 1'b0;
                    state_d  = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                if (!act_gnt) begin
                    gnt_d   = 2'b00;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A dropped strobe releases that port's ack and data, also suppressing a late ack
        if (!act_cpu) begin
            cpu_ack_d  = 1'b0;
            cpu_dati_d = '0;
        end
        if (!act_nic) begin
            nic_ack_d  = 1'b0;
            nic_dati_d = '0;
        end

`ifdef RF68000_ARB_WDOG_EN
        if (state_q != IDLE) begin
            if ((wcnt_q + WD_W'(1)) == WD_W'(WDOG_CYC)) begin
                cpu_ack_d = 1'b0;
                nic_ack_d = 1'b0;
                ram_en_d  = 1'b0;
                ram_we_d  = '0;
                gnt_d     = 2'b00;
                state_d   = IDLE;
                wdog_d    = 1'b1;
            end else begin
                wcnt_d = wcnt_q + WD_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b0;
            gnt_q      <= 2'b00;
            cnt_q      <= '0;
            cpu_ack_q  <= 1'b0;
            nic_ack_q  <= 1'b0;
            cpu_dati_q <= '0;
            nic_dati_q <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= '0;
            ram_adr_q  <= '0;
            ram_dati_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            cpu_ack_q  <= cpu_ack_d;
            nic_ack_q  <= nic_ack_d;
            cpu_dati_q <= cpu_dati_d;
            nic_dati_q <= nic_dati_d;
            ram_en_q   <= ram_en_d;
            ram_we_q   <= ram_we_d;
            ram_adr_q  <= ram_adr_d;
            ram_dati_q <= ram_dati_d;
        end
    end

`ifdef RF68000_ARB_WDOG_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
            wdog_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            wdog_q <= wdog_d;
        end
    end
    assign wdog_o = wdog_q;
`else
    assign wdog_o = 1'b0;
`endif

    assign gnt          = gnt_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.cpu_dati = cpu_dati_q;
    assign bus.nic_ack  = nic_ack_q;
    assign bus.nic_dati = nic_dati_q;
    assign bus.ram_en   = ram_en_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_adr  = ram_adr_q;
    assign bus.ram_dati = ram_dati_q;
endmodule

// File: tb/tb_rf68000_node_ram_rr_arbiter.sv
// Directed self-checking bench for rf68000_node_ram_rr_arbiter (RAM_LAT=3, WDOG_CYC=16).
module tb_rf68000_node_ram_rr_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] id;
    logic [1:0] gnt;
    logic       wdog_o;
    int         n_cmp = 0;
    int         n_err = 0;

    rf68000_node_ram_rr_arbiter_if bus ();

    rf68000_node_ram_rr_arbiter #(.RAM_LAT(3), .WDOG_CYC(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .id    (id),
        .bus   (bus),
        .gnt   (gnt),
        .wdog_o(wdog_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cpu_drive(input logic stb, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        bus.cpu_cyc = stb; bus.cpu_stb = stb; bus.cpu_we = we;
        bus.cpu_sel = 4'hF; bus.cpu_adr = adr; bus.cpu_dato = dat;
    endtask

    task automatic nic_drive(input logic stb, input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        bus.nic_cyc = stb; bus.nic_stb = stb; bus.nic_we = we;
        bus.nic_sel = sel; bus.nic_adr = adr; bus.nic_dato = dat;
    endtask

    // Ticks until the chosen port's ack is seen, bounded
    task automatic wait_ack(input bit nic, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if ((nic ? bus.nic_ack : bus.cpu_ack) === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; id = 4'd2; bus.ram_dato = 32'h0;
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        nic_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        n_cmp++;
        if ({bus.cpu_ack, bus.nic_ack, bus.ram_en, wdog_o, bus.ram_we, gnt} !== 10'h0) begin
            n_err++; $display("FAIL reset_ctrl: got %h want 000", {bus.cpu_ack, bus.nic_ack, bus.ram_en, wdog_o, bus.ram_we, gnt});
        end
        n_cmp++;
        if ({bus.cpu_dati, bus.nic_dati, bus.ram_adr, bus.ram_dati} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {bus.cpu_dati, bus.nic_dati, bus.ram_adr, bus.ram_dati});
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        bus.ram_dato = 32'hDEAD_BEEF;
        cpu_drive(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        tick();  // grant edge
        n_cmp++;
        if ({gnt, bus.ram_en, bus.ram_we, bus.cpu_ack} !== {2'b01, 1'b1, 4'h0, 1'b0}) begin
            n_err++; $display("FAIL rd_grant: got gnt=%b en=%b we=%h ack=%b want 01 1 0 0", gnt, bus.ram_en, bus.ram_we, bus.cpu_ack);
        end
        n_cmp++;
        if (bus.ram_adr !== 32'h0000_0100) begin
            n_err++; $display("FAIL rd_adr: got %h want 00000100", bus.ram_adr);
        end
        for (int e = 1; e <= 2; e++) begin
            tick();
            n_cmp++;
            if ({bus.ram_en, bus.cpu_ack} !== 2'b10) begin
                n_err++; $display("FAIL rd_wait%0d: got en=%b ack=%b want 1 0", e, bus.ram_en, bus.cpu_ack);
            end
        end
        tick();  // grant + 3
        n_cmp++;
        if ({bus.cpu_ack, bus.ram_en, bus.cpu_dati} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL rd_ack: got ack=%b en=%b dati=%h want 1 0 deadbeef", bus.cpu_ack, bus.ram_en, bus.cpu_dati);
        end
        tick();
        n_cmp++;
        if ({bus.cpu_ack, gnt} !== 3'b101) begin
            n_err++; $display("FAIL rd_hold: got ack=%b gnt=%b want 1 01", bus.cpu_ack, gnt);
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        n_cmp++;
        if ({bus.cpu_ack, bus.cpu_dati, gnt} !== 35'h0) begin
            n_err++; $display("FAIL rd_release: got ack=%b dati=%h gnt=%b want 0 0 00", bus.cpu_ack, bus.cpu_dati, gnt);
        end
    endtask

    task automatic test_nic_write();
        nic_drive(1'b1, 1'b1, 4'b0011, 32'hFF20_0010, 32'h1234_5678);
        tick();
        n_cmp++;
        if ({gnt, bus.ram_en, bus.ram_we, bus.nic_ack} !== {2'b10, 1'b1, 4'b0011, 1'b0}) begin
            n_err++; $display("FAIL wr_grant: got gnt=%b en=%b we=%b ack=%b want 10 1 0011 0", gnt, bus.ram_en, bus.ram_we, bus.nic_ack);
        end
        n_cmp++;
        if ({bus.ram_adr, bus.ram_dati} !== {32'hFF20_0010, 32'h1234_5678}) begin
            n_err++; $display("FAIL wr_payload: got adr=%h dat=%h want ff200010 12345678", bus.ram_adr, bus.ram_dati);
        end
        tick();
        n_cmp++;
        if ({bus.ram_we, bus.ram_en, bus.nic_ack} !== {4'b0000, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL wr_ack: got we=%b en=%b ack=%b want 0000 0 1", bus.ram_we, bus.ram_en, bus.nic_ack);
        end
        nic_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        n_cmp++;
        if ({bus.nic_ack, gnt} !== 3'b000) begin
            n_err++; $display("FAIL wr_release: got ack=%b gnt=%b want 0 00", bus.nic_ack, gnt);
        end
    endtask

    task automatic test_reset_mid_rd();
        bit ok;
        cpu_drive(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        tick();
        tick();
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, bus.ram_en, bus.cpu_ack, bus.ram_adr} !== 36'h0) begin
            n_err++; $display("FAIL rst_async: got gnt=%b en=%b ack=%b adr=%h want 0", gnt, bus.ram_en, bus.cpu_ack, bus.ram_adr);
        end
        #1 rst_i = 1'b0;
        tick();
        n_cmp++;
        if ({gnt, bus.ram_en} !== 3'b011) begin
            n_err++; $display("FAIL rst_idle_regrant: got gnt=%b en=%b want 01 1", gnt, bus.ram_en);
        end
        wait_ack(1'b0, ok);
        n_cmp++;
        if (!ok) begin
            n_err++; $display("FAIL rst_followup_ack: got no ack want ack");
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [1:0] exp_gnt;
        for (int r = 0; r < 4; r++) begin
            exp_gnt = (r % 2 == 0) ? 2'b10 : 2'b01;
            bus.ram_dato = 32'hA5A5_0000 + 32'(r);
            cpu_drive(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0BAD);
            nic_drive(1'b1, 1'b0, 4'hF, 32'hFF20_0040, 32'h0);
            tick();
            n_cmp++;
            if (gnt !== exp_gnt) begin
                n_err++; $display("FAIL sim_gnt%0d: got %b want %b", r, gnt, exp_gnt);
            end
            wait_ack(exp_gnt[1], ok);
            n_cmp++;
            if (!ok) begin
                n_err++; $display("FAIL sim_ack%0d: got no ack want ack", r);
            end
            n_cmp++;
            if ((exp_gnt[1] ? bus.cpu_ack : bus.nic_ack) !== 1'b0) begin
                n_err++; $display("FAIL sim_loser%0d: got loser ack 1 want 0", r);
            end
            if (exp_gnt[1]) begin
                n_cmp++;
                if (bus.nic_dati !== 32'hA5A5_0000 + 32'(r)) begin
                    n_err++; $display("FAIL sim_data%0d: got %h want %h", r, bus.nic_dati, 32'hA5A5_0000 + 32'(r));
                end
            end
            cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
            nic_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
            tick();
            n_cmp++;
            if (gnt !== 2'b00) begin
                n_err++; $display("FAIL sim_idle%0d: got %b want 00", r, gnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.ram_dato = 32'h0BAC_0B0C;
        nic_drive(1'b1, 1'b1, 4'hF, 32'hFF20_0080, 32'h5555_AAAA);
        tick();
        cpu_drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
        tick();
        nic_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        n_cmp++;
        if (gnt !== 2'b00) begin
            n_err++; $display("FAIL b2b_idle: got %b want 00", gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 2'b01) begin
            n_err++; $display("FAIL b2b_cpu_gnt: got %b want 01", gnt);
        end
        wait_ack(1'b0, ok);
        n_cmp++;
        if (!ok || bus.cpu_dati !== 32'h0BAC_0B0C) begin
            n_err++; $display("FAIL b2b_data: got ok=%b dati=%h want 1 0bac0b0c", ok, bus.cpu_dati);
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_miss();
        bus.ram_dato = 32'hFFFF_FFFF;
        nic_drive(1'b1, 1'b0, 4'hF, 32'hFF30_0000, 32'h0);
        tick();
        n_cmp++;
        if ({gnt, bus.nic_ack, bus.ram_en, bus.nic_dati} !== {2'b10, 1'b1, 1'b0, 32'h0}) begin
            n_err++; $display("FAIL nic_miss: got gnt=%b ack=%b en=%b dati=%h want 10 1 0 0", gnt, bus.nic_ack, bus.ram_en, bus.nic_dati);
        end
        tick();
        n_cmp++;
        if (bus.ram_en !== 1'b0) begin
            n_err++; $display("FAIL nic_miss_en: got %b want 0", bus.ram_en);
        end
        nic_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        cpu_drive(1'b1, 1'b0, 32'h0004_0000, 32'h0);
        for (int e = 0; e < 4; e++) begin
            tick();
            n_cmp++;
            if ({gnt, bus.cpu_ack, bus.ram_en} !== 4'b0000) begin
                n_err++; $display("FAIL cpu_miss%0d: got gnt=%b ack=%b en=%b want 0", e, gnt, bus.cpu_ack, bus.ram_en);
            end
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_mid_drop();
        bus.ram_dato = 32'h1111_2222;
        cpu_drive(1'b1, 1'b0, 32'h0000_0500, 32'h0);
        tick();
        cpu_drive(1'b0, 1'b0, 32'h0000_0500, 32'h0);
        tick();
        tick();
        tick();  // grant + 3: capture edge with the strobe gone
        n_cmp++;
        if ({bus.cpu_ack, bus.ram_en, gnt} !== 4'b0001) begin
            n_err++; $display("FAIL drop_ack: got ack=%b en=%b gnt=%b want 0 0 01", bus.cpu_ack, bus.ram_en, gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== 2'b00) begin
            n_err++; $display("FAIL drop_idle: got %b want 00", gnt);
        end
    endtask

`ifdef RF68000_ARB_WDOG_EN
    task automatic test_watchdog();
        bit ok;
        bus.ram_dato = 32'h7777_8888;
        cpu_drive(1'b1, 1'b0, 32'h0000_0600, 32'h0);
        tick();  // grant edge
        nic_drive(1'b1, 1'b0, 4'hF, 32'hFF20_0100, 32'h0);
        for (int e = 1; e < 15; e++) tick();
        tick();  // grant + 15
        n_cmp++;
        if ({wdog_o, bus.cpu_ack, gnt} !== 4'b0101) begin
            n_err++; $display("FAIL wdog_pre: got wdog=%b ack=%b gnt=%b want 0 1 01", wdog_o, bus.cpu_ack, gnt);
        end
        tick();  // grant + 16
        n_cmp++;
        if ({wdog_o, bus.cpu_ack, gnt} !== 4'b1000) begin
            n_err++; $display("FAIL wdog_fire: got wdog=%b ack=%b gnt=%b want 1 0 00", wdog_o, bus.cpu_ack, gnt);
        end
        tick();
        n_cmp++;
        if ({wdog_o, gnt} !== 3'b010) begin
            n_err++; $display("FAIL wdog_next: got wdog=%b gnt=%b want 0 10", wdog_o, gnt);
        end
        cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
        wait_ack(1'b1, ok);
        n_cmp++;
        if (!ok || bus.nic_dati !== 32'h7777_8888) begin
            n_err++; $display("FAIL wdog_nic_data: got ok=%b dati=%h want 1 77778888", ok, bus.nic_dati);
        end
        nic_drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_read();
        test_nic_write();
        test_reset_mid_rd();
        test_simultaneous();
        test_back_to_back();
        test_miss();
        test_mid_drop();
`ifdef RF68000_ARB_WDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
